axil_stream_tx_fifo: RTL and testbench
======================================

AXIL_STREAM_TX_FIFO -- requirements
Module: axil_stream_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, data-FIFO capacity in 32-bit words (power of 2, 16..4096).
REQ-002 SHALL have parameter MAX_PKTS, default 16, capacity of the committed-packet length queue (power of 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, single clock, all logic on rising edge; rst in 1, synchronous active-high reset.
REQ-004 SHALL have AXI-Lite slave write ports: s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1, s_axi_wdata in 32, s_axi_wstrb in 4 (ignored), s_axi_wvalid in 1, s_axi_wready out 1, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-005 SHALL have AXI-Lite slave read ports: s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1, s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-006 SHALL have AXI-Stream master ports: axi_str_txd_tvalid out 1, axi_str_txd_tready in 1, axi_str_txd_tlast out 1, axi_str_txd_tdata out 32.
REQ-007 SHALL have tx_error out 1, sticky error flag, cleared only by reset/soft reset.

Function
REQ-008 SHALL decode only address bits [7:0]: 0x08 TDFR (W), 0x0C TDFV (R), 0x10 TDFD (W), 0x14 TLR (W), 0x1C PKTS (R); other writes are ignored with OKAY, other reads return 0 with OKAY.
REQ-009 SHALL accept a write only in a cycle with awvalid && wvalid && !bvalid, asserting awready and wready together for exactly that cycle; bvalid rises the next cycle and holds until bready.
REQ-010 SHALL accept a read only when arvalid && !rvalid, asserting arready for that cycle; rvalid and rdata valid the next cycle, held stable until rready.
REQ-011 TDFD write SHALL push wdata into the data FIFO and increment the uncommitted-word count; if the FIFO holds DEPTH words, the word is dropped, bresp = 2'b10 (SLVERR), tx_error set.
REQ-012 TLR write SHALL commit a packet of N = ceil(wdata[15:0]/4) words, pushing N into the length queue and subtracting N from the uncommitted count.
REQ-013 TLR SHALL be rejected (SLVERR, tx_error set, no state change) if N == 0, N > uncommitted count, or the length queue holds MAX_PKTS entries.
REQ-014 TDFR write with wdata == 32'h000000A5 SHALL perform a soft reset identical to rst, completing with OKAY; other TDFR values are ignored.
REQ-015 TDFV read SHALL return DEPTH minus total stored words (committed + uncommitted), zero-extended.
REQ-016 PKTS read SHALL return the number of committed packets not yet fully transmitted, counting the one in flight.
REQ-017 TX FSM SHALL have states IDLE and SEND: in IDLE with the length queue non-empty, pop the length into a remaining counter and go to SEND; otherwise stay in IDLE.
REQ-018 In SEND, tvalid SHALL be 1 and tdata SHALL equal the data-FIFO head; tlast = 1 when remaining == 1; each tvalid && tready pops one word and decrements remaining.
REQ-019 On the handshake with tlast = 1, the FSM SHALL return to IDLE; tvalid is 0 for at least one cycle between packets.
REQ-020 SHALL hold tvalid, tdata and tlast stable while tvalid && !tready.
REQ-021 Latency: for a TLR write handshake in cycle C with the FSM idle, first-flit tvalid SHALL be 1 in cycle C+2.
REQ-022 A simultaneous TDFD push and stream pop in the same cycle SHALL leave the stored-word count unchanged, with both operations taking effect.
REQ-023 A TLR commit in the same cycle as a FSM length-queue pop SHALL leave the queue count unchanged.
REQ-024 Uncommitted words SHALL never be transmitted.
REQ-025 All counters SHALL be wide enough to hold DEPTH and MAX_PKTS without wrap; FIFO pointers wrap modulo DEPTH or MAX_PKTS.

Reset
REQ-026 On rst (or soft reset) SHALL clear FIFOs, queues, counters and tx_error, and put the FSM in IDLE.
REQ-027 After reset, outputs SHALL be: awready/wready/arready/bvalid/rvalid/tvalid/tlast = 0, bresp/rresp = 0, rdata/tdata = 0.
REQ-028 Reset mid-packet SHALL drop tvalid the following cycle without emitting tlast; the packet is discarded.
REQ-029 Soft reset SHALL still return its write response (bvalid) normally.

Verification
REQ-030 3 TDFD writes (0x11,0x22,0x33), TLR=12, tready=1 -> tdata 0x11,0x22,0x33 on consecutive cycles, tlast only on 0x33, first tvalid 2 cycles after TLR handshake.
REQ-031 TLR=5 after 2 TDFD writes -> 2 flits, tlast on 2nd; TLR=0 or TLR=12 with 2 words -> SLVERR, tx_error=1, no stream output.
REQ-032 DEPTH+1 TDFD writes, tready=0 -> last write SLVERR, TDFV reads 0, tx_error=1.
REQ-033 MAX_PKTS+1 one-word packets committed with tready=0 -> last TLR SLVERR; PKTS reads MAX_PKTS; release tready -> exactly MAX_PKTS tlast flits.
REQ-034 4-word packet, tready toggled randomly -> data held stable while stalled, order preserved; TDFD writes during transmission leave TDFV consistent.
REQ-035 TDFR=0xA5 mid-packet -> tvalid 0 next cycle, TDFV = DEPTH, PKTS = 0, tx_error = 0, bresp OKAY.

Source files
------------

// File: rtl/axil_stream_tx_fifo.sv
// rtl/axil_stream_tx_fifo.sv - AXI-Lite programmed transmit FIFO feeding an AXI-Stream master
//
// Purpose: words written to TDFD collect in a data FIFO as "uncommitted" data.
// A TLR write commits the oldest uncommitted words as one packet by pushing its
// word count into a length queue. A two-state TX FSM pops lengths and streams
// exactly that many words out, with tlast on the final word.
//
// Ports:
//   clk, rst                          single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*                   AXI-Lite write channel (TDFR, TDFD, TLR)
//   s_axi_ar*/r*                      AXI-Lite read channel (TDFV, PKTS)
//   axi_str_txd_t*                    AXI-Stream transmit master
//   tx_error                          sticky overflow / bad-commit flag
module axil_stream_tx_fifo #(
    parameter int DEPTH    = 512,
    parameter int MAX_PKTS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        axi_str_txd_tvalid,
    input  logic        axi_str_txd_tready,
    output logic        axi_str_txd_tlast,
    output logic [31:0] axi_str_txd_tdata,
    output logic        tx_error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(MAX_PKTS);
    localparam int QW = PW + 1;

    localparam logic [7:0] ADDR_TDFR = 8'h08;
    localparam logic [7:0] ADDR_TDFV = 8'h0C;
    localparam logic [7:0] ADDR_TDFD = 8'h10;
    localparam logic [7:0] ADDR_TLR  = 8'h14;
    localparam logic [7:0] ADDR_PKTS = 8'h1C;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d, uncom_q, uncom_d, rem_q, rem_d;
    logic [PW-1:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic [QW-1:0] lq_cnt_q, lq_cnt_d, pkts_q, pkts_d;
    logic          err_q, err_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] lq_mem [MAX_PKTS];

    logic          wr_fire, rd_fire, is_tdfd, is_tlr, soft_rst;
    logic          fifo_full, push, pop, pop_last, tlr_ok, commit, lq_pop;
    logic [16:0]   tlr_sum;
    logic [31:0]   tlr_n;
    logic          unused;

    assign unused = ^{s_axi_wstrb, s_axi_awaddr[31:8], s_axi_araddr[31:8]};

    assign wr_fire  = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !rst;
    assign rd_fire  = s_axi_arvalid && !rvalid_q && !rst;
    assign is_tdfd  = wr_fire && (s_axi_awaddr[7:0] == ADDR_TDFD);
    assign is_tlr   = wr_fire && (s_axi_awaddr[7:0] == ADDR_TLR);
    assign soft_rst = wr_fire && (s_axi_awaddr[7:0] == ADDR_TDFR) && (s_axi_wdata == 32'h0000_00A5);

    // Byte length rounded up to whole 32-bit words.
    assign tlr_sum = {1'b0, s_axi_wdata[15:0]} + 17'd3;
    assign tlr_n   = 32'(tlr_sum[16:2]);

    assign fifo_full = (cnt_q == CW'(DEPTH));
    assign push      = is_tdfd && !fifo_full;
    // The packet limit counts the in-flight packet too, so PKTS never exceeds MAX_PKTS.
    assign tlr_ok    = (tlr_n != 32'd0) && (tlr_n <= 32'(uncom_q)) && (pkts_q != QW'(MAX_PKTS));
    assign commit    = is_tlr && tlr_ok;
    assign lq_pop    = (state_q == IDLE) && (lq_cnt_q != '0);
    assign pop       = (state_q == SEND) && axi_str_txd_tready;
    assign pop_last  = pop && (rem_q == CW'(1));

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        uncom_d  = uncom_q + CW'(push) - (commit ? CW'(tlr_n) : CW'(0));
        lq_wr_d  = lq_wr_q + (commit ? PW'(1) : PW'(0));
        lq_rd_d  = lq_rd_q + (lq_pop ? PW'(1) : PW'(0));
        lq_cnt_d = lq_cnt_q + QW'(commit) - QW'(lq_pop);
        pkts_d   = pkts_q + QW'(commit) - QW'(pop_last);
        err_d    = err_q || (is_tdfd && fifo_full) || (is_tlr && !tlr_ok);

        if (lq_pop) begin
            rem_d   = lq_mem[lq_rd_q];
            state_d = SEND;
        end else if (pop) begin
            rem_d = rem_q - CW'(1);
            if (pop_last) begin
                state_d = IDLE;
            end
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = ((is_tdfd && fifo_full) || (is_tlr && !tlr_ok)) ? 2'b10 : 2'b00;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            if (s_axi_araddr[7:0] == ADDR_TDFV) begin
                rdata_d = 32'(CW'(DEPTH) - cnt_q);
            end else if (s_axi_araddr[7:0] == ADDR_PKTS) begin
                rdata_d = 32'(pkts_q);
            end else begin
                rdata_d = 32'd0;
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Soft reset clears the datapath but leaves the AXI-Lite channels alone so
    // the TDFR write still completes with its response.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            uncom_q  <= '0;
            lq_wr_q  <= '0;
            lq_rd_q  <= '0;
            lq_cnt_q <= '0;
            pkts_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            uncom_q  <= uncom_d;
            lq_wr_q  <= lq_wr_d;
            lq_rd_q  <= lq_rd_d;
            lq_cnt_q <= lq_cnt_d;
            pkts_q   <= pkts_d;
            err_q    <= err_d;
        end
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_axi_wdata;
        end
        if (commit) begin
            lq_mem[lq_wr_q] <= CW'(tlr_n);
        end
    end

    assign s_axi_awready      = wr_fire;
    assign s_axi_wready       = wr_fire;
    assign s_axi_bvalid       = bvalid_q;
    assign s_axi_bresp        = bresp_q;
    assign s_axi_arready      = rd_fire;
    assign s_axi_rvalid       = rvalid_q;
    assign s_axi_rdata        = rdata_q;
    assign s_axi_rresp        = 2'b00;
    assign axi_str_txd_tvalid = (state_q == SEND);
    assign axi_str_txd_tdata  = (state_q == SEND) ? mem[rd_ptr_q] : 32'd0;
    assign axi_str_txd_tlast  = (state_q == SEND) && (rem_q == CW'(1));
    assign tx_error           = err_q;
endmodule

// File: tb/tb_axil_stream_tx_fifo.sv
// tb/tb_axil_stream_tx_fifo.sv - scoreboard bench for axil_stream_tx_fifo
module tb_axil_stream_tx_fifo;
    localparam int DEPTH = 16;
    localparam int MAXP  = 4;
    localparam logic [7:0] TDFR = 8'h08, TDFV = 8'h0C, TDFD = 8'h10, TLR = 8'h14, PKTS = 8'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata, axi_str_txd_tdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        axi_str_txd_tvalid, axi_str_txd_tready, axi_str_txd_tlast, tx_error;

    axil_stream_tx_fifo #(.DEPTH(DEPTH), .MAX_PKTS(MAXP)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .axi_str_txd_tvalid(axi_str_txd_tvalid), .axi_str_txd_tready(axi_str_txd_tready),
        .axi_str_txd_tlast(axi_str_txd_tlast), .axi_str_txd_tdata(axi_str_txd_tdata),
        .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int hs_cyc, first_tv_cyc, last_flit_cyc, tlast_cnt = 0;
    logic [32:0] sb [$];
    logic        hold_chk_en = 1'b1, rand_en = 1'b0, post_tv;
    logic        prev_tv = 1'b0, prev_tr = 1'b0;
    logic [33:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        tests++;
        fails++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Stream monitor: pops the scoreboard per flit and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_tv = 1'b0;
            prev_tr = 1'b0;
        end else begin
            if (hold_chk_en && prev_tv && !prev_tr)
                chk("stall_hold", {30'd0, axi_str_txd_tvalid, axi_str_txd_tlast, axi_str_txd_tdata}, {30'd0, prev_word});
            if (axi_str_txd_tvalid && !prev_tv) first_tv_cyc = cyc;
            if (axi_str_txd_tvalid && axi_str_txd_tready) begin
                tlast_cnt += int'(axi_str_txd_tlast);
                last_flit_cyc = cyc;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL stray_flit observed=0x%0h expected=none", {axi_str_txd_tlast, axi_str_txd_tdata});
                end else begin
                    chk("flit", {31'd0, axi_str_txd_tlast, axi_str_txd_tdata}, {31'd0, sb.pop_front()});
                end
            end
            prev_tv   = axi_str_txd_tvalid;
            prev_tr   = axi_str_txd_tready;
            prev_word = {axi_str_txd_tvalid, axi_str_txd_tlast, axi_str_txd_tdata};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) axi_str_txd_tready = 1'($urandom_range(0, 1));
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] r);
        int n;
        s_axi_awaddr = {24'h0, a};
        s_axi_wdata = d;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_awready) fail_now("aw_handshake");
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        post_tv = axi_str_txd_tvalid;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_bvalid) fail_now("b_handshake");
        r = s_axi_bvalid ? s_axi_bresp : 2'b11;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [1:0] exp);
        logic [1:0] r;
        axi_write(a, d, r);
        chk(tag, 64'(r), 64'(exp));
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        int n;
        s_axi_araddr = {24'h0, a};
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_arready) fail_now("ar_handshake");
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        chk(tag, {30'd0, s_axi_rresp, s_axi_rdata}, {32'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int ok_cnt;
        logic [1:0] r;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1; axi_str_txd_tready = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        chk("rst_valid", {s_axi_bvalid, s_axi_rvalid, axi_str_txd_tvalid, axi_str_txd_tlast}, 4'b0000);
        chk("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata, axi_str_txd_tdata}, 68'd0);
        chk("rst_error", tx_error, 1'b0);
        wait_cycles(1);

        // Three-word packet at full throughput.
        wr("tdfd_ok", TDFD, 32'h11, 2'b00); sb.push_back({1'b0, 32'h11});
        wr("tdfd_ok", TDFD, 32'h22, 2'b00); sb.push_back({1'b0, 32'h22});
        wr("tdfd_ok", TDFD, 32'h33, 2'b00); sb.push_back({1'b1, 32'h33});
        first_tv_cyc = -1;
        wr("tlr12_ok", TLR, 32'd12, 2'b00);
        drain("drain_3w");
        chk("first_flit_latency", 64'(first_tv_cyc - hs_cyc), 64'd2);
        chk("back_to_back", 64'(last_flit_cyc - hs_cyc), 64'd4);

        // Rounded-up length, then rejected commits.
        wr("tdfd_ok", TDFD, 32'hA1, 2'b00); sb.push_back({1'b0, 32'hA1});
        wr("tdfd_ok", TDFD, 32'hA2, 2'b00); sb.push_back({1'b1, 32'hA2});
        wr("tlr5_ok", TLR, 32'd5, 2'b00);
        drain("drain_tlr5");
        wr("tdfd_ok", TDFD, 32'hB1, 2'b00);
        wr("tdfd_ok", TDFD, 32'hB2, 2'b00);
        wr("tlr0_slverr", TLR, 32'd0, 2'b10);
        wr("tlr12_slverr", TLR, 32'd12, 2'b10);
        wait_cycles(5);
        chk("tx_error_set", tx_error, 1'b1);
        rd("tdfv_uncommitted", TDFV, 32'd14);
        rd("pkts_zero", PKTS, 32'd0);
        sb.push_back({1'b0, 32'hB1}); sb.push_back({1'b1, 32'hB2});
        wr("tlr8_ok", TLR, 32'd8, 2'b00);
        drain("drain_tlr8");
        wr("tdfr_other", TDFR, 32'h5A, 2'b00);
        chk("tdfr_other_keeps_err", tx_error, 1'b1);
        wr("unmapped_wr", 8'h40, 32'hFFFF_FFFF, 2'b00);
        rd("unmapped_rd", 8'h20, 32'd0);
        rd("writeonly_rd", TDFD, 32'd0);
        wr("soft_rst", TDFR, 32'hA5, 2'b00);
        chk("soft_rst_err", tx_error, 1'b0);

        // Overflow the data FIFO with the stream stalled.
        axi_str_txd_tready = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(TDFD, 32'h100 + 32'(i), r);
            if (r == 2'b00) ok_cnt++;
        end
        chk("fill_all_ok", 64'(ok_cnt), 64'(DEPTH));
        wr("overflow_slverr", TDFD, 32'hDEAD, 2'b10);
        rd("tdfv_full", TDFV, 32'd0);
        chk("overflow_err", tx_error, 1'b1);
        wr("soft_rst", TDFR, 32'hA5, 2'b00);
        rd("tdfv_after_sr", TDFV, 32'(DEPTH));

        // Length-queue full: MAXP+1 single-word packets, stalled.
        for (int i = 0; i <= MAXP; i++) begin
            wr("tdfd_ok", TDFD, 32'h200 + 32'(i), 2'b00);
            if (i < MAXP) begin
                sb.push_back({1'b1, 32'h200 + 32'(i)});
                wr("tlr4_ok", TLR, 32'd4, 2'b00);
            end else begin
                wr("tlr_qfull_slverr", TLR, 32'd4, 2'b10);
            end
        end
        rd("pkts_max", PKTS, 32'(MAXP));
        rd("tdfv_qfull", TDFV, 32'(DEPTH - MAXP - 1));
        tlast_cnt = 0;
        axi_str_txd_tready = 1'b1;
        drain("drain_qfull");
        wait_cycles(5);
        chk("tlast_count", 64'(tlast_cnt), 64'(MAXP));
        rd("tdfv_leftover", TDFV, 32'(DEPTH - 1));
        wr("soft_rst", TDFR, 32'hA5, 2'b00);

        // Random back-pressure with writes during transmission.
        for (int i = 0; i < 4; i++) begin
            wr("tdfd_ok", TDFD, 32'hC0 + 32'(i), 2'b00);
            sb.push_back({(i == 3), 32'hC0 + 32'(i)});
        end
        rand_en = 1'b1;
        wr("tlr16_ok", TLR, 32'd16, 2'b00);
        wr("tdfd_during_tx", TDFD, 32'hE0, 2'b00);
        wr("tdfd_during_tx", TDFD, 32'hE1, 2'b00);
        drain("drain_random");
        rand_en = 1'b0;
        axi_str_txd_tready = 1'b1;
        rd("tdfv_consistent", TDFV, 32'(DEPTH - 2));
        rd("pkts_done", PKTS, 32'd0);
        wr("soft_rst", TDFR, 32'hA5, 2'b00);

        // Soft reset in the middle of a stalled packet.
        axi_str_txd_tready = 1'b0;
        wr("tdfd_ok", TDFD, 32'hD1, 2'b00);
        wr("tdfd_ok", TDFD, 32'hD2, 2'b00);
        wr("tlr_bad", TLR, 32'd0, 2'b10);
        sb.push_back({1'b0, 32'hD1}); sb.push_back({1'b1, 32'hD2});
        wr("tlr8_ok", TLR, 32'd8, 2'b00);
        chk("tvalid_before_sr", axi_str_txd_tvalid, 1'b1);
        hold_chk_en = 1'b0;
        sb.delete();
        wr("sr_mid_pkt_okay", TDFR, 32'hA5, 2'b00);
        chk("sr_tvalid_drop", post_tv, 1'b0);
        axi_str_txd_tready = 1'b1;
        wait_cycles(5);
        hold_chk_en = 1'b1;
        rd("sr_tdfv", TDFV, 32'(DEPTH));
        rd("sr_pkts", PKTS, 32'd0);
        chk("sr_err_clear", tx_error, 1'b0);

        // Hard reset in the middle of a stalled packet.
        axi_str_txd_tready = 1'b0;
        wr("tdfd_ok", TDFD, 32'hF1, 2'b00);
        wr("tdfd_ok", TDFD, 32'hF2, 2'b00);
        sb.push_back({1'b0, 32'hF1}); sb.push_back({1'b1, 32'hF2});
        wr("tlr8_ok", TLR, 32'd8, 2'b00);
        hold_chk_en = 1'b0;
        sb.delete();
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_pkt", {axi_str_txd_tvalid, axi_str_txd_tlast}, 2'b00);
        wait_cycles(1);
        axi_str_txd_tready = 1'b1;
        wait_cycles(5);
        hold_chk_en = 1'b1;
        rd("rst_tdfv", TDFV, 32'(DEPTH));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
